// File: rtl/mem_ls_ctrl.sv
// mem_ls_ctrl: load/store sequencer driving bus selects and memory strobes; define MEM_LS_MFC_TIMEOUT_EN to bound MFC waits by TMO_CYC
module mem_ls_ctrl #(
  parameter int INSTR_W = 16,
  parameter int OPC_W = 4,
  parameter int FLD_W = 6,
  parameter int NREG = 6,
  parameter logic [OPC_W-1:0] STORE_OPC = 4'b0011,
  parameter logic [OPC_W-1:0] LOAD_OPC = 4'b0100,
  parameter int TMO_CYC = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mfc,
  output logic               pc_inc,
  output logic               mar_en,
  output logic               mem_en,
  output logic               mem_rw,
  output logic               mdr_en_read,
  output logic               mdr_en_write,
  output logic               mdr_out,
  output logic [NREG-1:0]    reg_out,
  output logic [NREG-1:0]    reg_in,
  output logic               done,
  output logic               err,
  output logic               busy
);
  typedef enum logic [3:0] {
    IDLE, FETCH, ADDR, ST_DATA, ST_MDR, ST_WAIT,
    LD_WAIT, LD_CAP, LD_DRV, LD_WB, DONE, ERR
  } state_t;
  state_t state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [OPC_W-1:0] opc_in, opc_q;
  logic [FLD_W-1:0] p1_in, p2_in, p1_d, p2_d;
  logic is_ls, fld_bad;
  logic [NREG-1:0] oh1, oh2, reg_out_d, reg_in_d;
`ifdef MEM_LS_MFC_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif
  assign opc_in  = instr[INSTR_W-1 -: OPC_W];
  assign opc_q   = instr_q[INSTR_W-1 -: OPC_W];
  assign p1_in   = instr[2*FLD_W-1:FLD_W];
  assign p2_in   = instr[FLD_W-1:0];
  assign p1_d    = instr_d[2*FLD_W-1:FLD_W];
  assign p2_d    = instr_d[FLD_W-1:0];
  assign is_ls   = (opc_in == STORE_OPC) || (opc_in == LOAD_OPC);
  assign fld_bad = (32'(p1_in) >= NREG) || (32'(p2_in) >= NREG);
  // next state, latched instruction and the output values that state will present
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
`ifdef MEM_LS_MFC_TIMEOUT_EN
    cnt_d = (state_q inside {ST_WAIT, LD_WAIT}) && !mfc ? cnt_q + 8'd1 : 8'd0;
`endif
    case (state_q)
      IDLE: if (start && is_ls) begin
        instr_d = instr;
        state_d = fld_bad ? ERR : FETCH;
      end
      FETCH:   state_d = ADDR;
      ADDR:    state_d = (opc_q == STORE_OPC) ? ST_DATA : LD_WAIT;
      ST_DATA: state_d = ST_MDR;
      ST_MDR:  state_d = ST_WAIT;
      ST_WAIT, LD_WAIT: begin
        if (mfc) state_d = (state_q == ST_WAIT) ? DONE : LD_CAP;
`ifdef MEM_LS_MFC_TIMEOUT_EN
        else if (cnt_q == 8'(TMO_CYC - 1)) state_d = ERR;
`endif
      end
      LD_CAP:  state_d = LD_DRV;
      LD_DRV:  state_d = LD_WB;
      LD_WB:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    oh1 = '0;
    oh2 = '0;
    for (int k = 0; k < NREG; k++) begin
      oh1[k] = 32'(p1_d) == k;
      oh2[k] = 32'(p2_d) == k;
    end
    reg_out_d = (state_d inside {FETCH, ADDR}) ? oh2 :
                (state_d inside {ST_DATA, ST_MDR}) ? oh1 : '0;
    reg_in_d  = (state_d == LD_WB) ? oh1 : '0;
  end
  // state, instruction latch and registered Moore outputs; reset clears everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      pc_inc       <= 1'b0;
      mar_en       <= 1'b0;
      mem_en       <= 1'b0;
      mem_rw       <= 1'b0;
      mdr_en_read  <= 1'b0;
      mdr_en_write <= 1'b0;
      mdr_out      <= 1'b0;
      reg_out      <= '0;
      reg_in       <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc_inc       <= state_d == FETCH;
      mar_en       <= state_d == ADDR;
      mem_en       <= state_d inside {ST_WAIT, LD_WAIT, LD_CAP};
      mem_rw       <= state_d inside {LD_WAIT, LD_CAP};
      mdr_en_read  <= state_d == LD_CAP;
      mdr_en_write <= state_d == ST_MDR;
      mdr_out      <= state_d inside {LD_DRV, LD_WB};
      reg_out      <= reg_out_d;
      reg_in       <= reg_in_d;
      done         <= state_d inside {DONE, ERR};
      err          <= state_d == ERR;
      busy         <= state_d != IDLE;
    end
  end
`ifdef MEM_LS_MFC_TIMEOUT_EN
  // wait-cycle counter, cleared whenever the block is not stalled on mfc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_mem_ls_ctrl.sv
// tb_mem_ls_ctrl: randomized scoreboard bench for mem_ls_ctrl
module tb_mem_ls_ctrl;
  localparam int NREG = 6;
  localparam int TMO = 15;
  localparam int VW = 7 + 2 * NREG + 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mfc = 1'b0;
  logic [15:0] instr = '0;
  logic pc_inc, mar_en, mem_en, mem_rw, mdr_en_read, mdr_en_write, mdr_out, done, err, busy;
  logic [NREG-1:0] reg_out, reg_in;
  int n_chk = 0, n_fail = 0;
  logic [VW-1:0] q[$];
  logic [VW-1:0] exp_v;
  wire [VW-1:0] dut_v = {pc_inc, mar_en, mem_en, mem_rw, mdr_en_read, mdr_en_write,
                         mdr_out, reg_out, reg_in, done, err, busy};

  mem_ls_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .mfc(mfc),
    .pc_inc(pc_inc), .mar_en(mar_en), .mem_en(mem_en), .mem_rw(mem_rw),
    .mdr_en_read(mdr_en_read), .mdr_en_write(mdr_en_write), .mdr_out(mdr_out),
    .reg_out(reg_out), .reg_in(reg_in), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] ev(input bit pc, mar, men, rw, mr, mw, mo,
                                       input logic [NREG-1:0] ro, ri, input bit dn, er);
    return {pc, mar, men, rw, mr, mw, mo, ro, ri, dn, er, 1'b1};
  endfunction

  function automatic logic [NREG-1:0] oh(input int f);
    logic [NREG-1:0] r = '0;
    if (f < NREG) r[f] = 1'b1;
    return r;
  endfunction

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // monitor: every cycle the DUT presents activity (or activity is owed) one expected vector is consumed
  always @(negedge clk) begin
    if (!rst && (dut_v != '0 || q.size() > 0)) begin
      exp_v = (q.size() > 0) ? q.pop_front() : '0;
      check("trace", dut_v, exp_v);
    end
  end

  // issue one instruction; d = mfc=0 wait cycles before mfc rises; cut >= 0 stops after cut cycles
  task automatic run(input logic [15:0] ins, input int d, input int cut);
    logic [VW-1:0] t[$];
    int opc = int'(ins[15:12]);
    int p1 = int'(ins[11:6]);
    int p2 = int'(ins[5:0]);
    bit st = (opc == 3);
    bit ls = (opc == 3) || (opc == 4);
    int we = st ? 5 : 3;
    bit tmo = 1'b0;
    int n = d + 1;
    int lim;
`ifdef MEM_LS_MFC_TIMEOUT_EN
    tmo = (d >= TMO);
    if (tmo) n = TMO;
`endif
    if (ls && (p1 >= NREG || p2 >= NREG)) t.push_back(ev(0,0,0,0,0,0,0,'0,'0,1,1));
    else if (ls) begin
      t.push_back(ev(1,0,0,0,0,0,0,oh(p2),'0,0,0));
      t.push_back(ev(0,1,0,0,0,0,0,oh(p2),'0,0,0));
      if (st) begin
        t.push_back(ev(0,0,0,0,0,0,0,oh(p1),'0,0,0));
        t.push_back(ev(0,0,0,0,0,1,0,oh(p1),'0,0,0));
        repeat (n) t.push_back(ev(0,0,1,0,0,0,0,'0,'0,0,0));
      end else begin
        repeat (n) t.push_back(ev(0,0,1,1,0,0,0,'0,'0,0,0));
        if (!tmo) begin
          t.push_back(ev(0,0,1,1,1,0,0,'0,'0,0,0));
          t.push_back(ev(0,0,0,0,0,0,1,'0,'0,0,0));
          t.push_back(ev(0,0,0,0,0,0,1,'0,oh(p1),0,0));
        end
      end
      t.push_back(tmo ? ev(0,0,0,0,0,0,0,'0,'0,1,1) : ev(0,0,0,0,0,0,0,'0,'0,1,0));
    end
    lim = (cut >= 0) ? cut : t.size();
    start = 1'b1;
    instr = ins;
    @(posedge clk);
    #1;
    for (int i = 0; i < lim; i++) q.push_back(t[i]);
    start = 1'b0;
    if (!ls) begin
      @(negedge clk);
      check("ignored_opc", dut_v, '0);
      @(posedge clk);
      #1;
    end
    for (int k = 1; k <= lim; k++) begin
      mfc = (k < we) ? 1'($urandom) : (k >= we + d);
      start = 1'($urandom);
      instr = 16'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_v, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", dut_v, '0);
    run(16'h3081, 0, -1);
    run(16'h4003, 4, -1);
    run(16'h5000, 0, -1);
    run(16'h3007, 0, -1);
    run(16'h4003, 0, 3);
    check("before_rst_ldcap", dut_v, ev(0,0,1,1,1,0,0,'0,'0,0,0));
    rst = 1'b1;
    #1;
    check("rst_async_clear", dut_v, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(16'h3081, 1, -1);
`ifdef MEM_LS_MFC_TIMEOUT_EN
    run(16'h3081, TMO, -1);
    run(16'h3081, TMO - 1, -1);
    run(16'h4003, TMO + 3, -1);
`endif
    for (int i = 0; i < 60; i++) begin
      logic [15:0] w = 16'($urandom);
      int sel = $urandom_range(0, 9);
      int dd;
      w[15:12] = (sel < 4) ? 4'd3 : (sel < 8) ? 4'd4 : ((w[15:12] == 4'd3 || w[15:12] == 4'd4) ? 4'd9 : w[15:12]);
      w[11:6] = 6'($urandom_range(0, NREG));
      w[5:0]  = 6'($urandom_range(0, NREG));
`ifdef MEM_LS_MFC_TIMEOUT_EN
      dd = $urandom_range(0, TMO + 3);
`else
      dd = $urandom_range(0, 6);
`endif
      run(w, dd, -1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
